// File: rtl/mem_bus_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter_if
// Brief   : Requester-side and memory-side signals of the two-port memory
//           arbiter, named from the arbiter's point of view.
// Revision: 1.0
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [1:0]    i_req;
    logic [1:0]    i_we;
    logic [AW-1:0] i_addr0;
    logic [AW-1:0] i_addr1;
    logic [DW-1:0] i_wdata0;
    logic [DW-1:0] i_wdata1;
    logic [1:0]    o_gnt;
    logic [1:0]    o_rvalid;
    logic [DW-1:0] o_rdata;
    logic          o_busy;
    logic          o_mem_en;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata;

    modport slave (
        input  i_req, i_we, i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
        output o_gnt, o_rvalid, o_rdata, o_busy,
               o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_req, i_we, i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
        input  o_gnt, o_rvalid, o_rdata, o_busy,
               o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Shares one single-port memory between fetch (port 0) and
//           decode_exec (port 1); sequences issue/wait/capture per access.
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int MEM_LAT    = 1,
    parameter int FIXED_PRIO = 0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] c_cnt_init = 4'(MEM_LAT - 1);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
            $error("mem_bus_arbiter: MEM_LAT must be within 1..15");
        end
    endgenerate

    state_t        r_state,      w_state_nxt;
    logic [3:0]    r_cnt,        w_cnt_nxt;
    logic          r_last_gnt,   w_last_nxt;
    logic          r_id,         w_id_nxt;
    logic          r_we_l,       w_we_nxt;
    logic [1:0]    r_gnt,        w_gnt_nxt;
    logic [1:0]    r_rvalid,     w_rvalid_nxt;
    logic [DW-1:0] r_rdata,      w_rdata_nxt;
    logic          r_busy,       w_busy_nxt;
    logic          r_mem_en,     w_mem_en_nxt;
    logic          r_mem_we,     w_mem_we_nxt;
    logic [AW-1:0] r_mem_addr,   w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata,  w_mem_wdata_nxt;
    logic          w_pick;

    // On a tie, round-robin hands the slot to the port not served last.
    always_comb begin
        if (bus.i_req[0] && bus.i_req[1]) begin
            w_pick = (FIXED_PRIO != 0) ? 1'b1 : ~r_last_gnt;
        end else begin
            w_pick = bus.i_req[1];
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_last_nxt      = r_last_gnt;
        w_id_nxt        = r_id;
        w_we_nxt        = r_we_l;
        w_rdata_nxt     = r_rdata;
        w_gnt_nxt       = 2'b00;
        w_rvalid_nxt    = 2'b00;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;

        case (r_state)
            S_IDLE: begin
                if (|bus.i_req) begin
                    // Every output is a flop, so the ISSUE-cycle values are loaded here.
                    w_id_nxt        = w_pick;
                    w_we_nxt        = bus.i_we[w_pick];
                    w_gnt_nxt       = {w_pick, ~w_pick};
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = bus.i_we[w_pick];
                    w_mem_addr_nxt  = w_pick ? bus.i_addr1  : bus.i_addr0;
                    w_mem_wdata_nxt = w_pick ? bus.i_wdata1 : bus.i_wdata0;
                    w_state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_last_nxt = r_id;
                if (r_we_l) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = c_cnt_init;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_rdata_nxt  = bus.i_mem_rdata;
                    w_rvalid_nxt = {r_id, ~r_id};
                    w_state_nxt  = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_last_gnt  <= 1'b1;
            r_id        <= 1'b0;
            r_we_l      <= 1'b0;
            r_gnt       <= 2'b00;
            r_rvalid    <= 2'b00;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last_gnt  <= w_last_nxt;
            r_id        <= w_id_nxt;
            r_we_l      <= w_we_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rvalid    <= w_rvalid_nxt;
            r_rdata     <= w_rdata_nxt;
            r_busy      <= w_busy_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    assign bus.o_gnt       = r_gnt;
    assign bus.o_rvalid    = r_rvalid;
    assign bus.o_rdata     = r_rdata;
    assign bus.o_busy      = r_busy;
    assign bus.o_mem_en    = r_mem_en;
    assign bus.o_mem_we    = r_mem_we;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Brief   : Three arbiter instances (LAT1/RR, LAT1/fixed, LAT4/RR) driven by
//           a requester model, a latency-exact memory model and a scoreboard.
// Revision: 1.0
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int N = 3;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    typedef struct packed {
        logic [1:0] gnt;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } acc_t;

    typedef struct packed {
        logic [1:0] rv;
        logic [7:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] req_a [N];
    logic [1:0] we_a [N];
    logic [7:0] addr0_a [N];
    logic [7:0] addr1_a [N];
    logic [7:0] wdata0_a [N];
    logic [7:0] wdata1_a [N];
    logic [1:0] gnt_a [N];
    logic [1:0] rvalid_a [N];
    logic [7:0] rdata_a [N];
    logic       busy_a [N];
    logic       mem_en_a [N];
    logic       mem_we_a [N];
    logic [7:0] mem_addr_a [N];
    logic [7:0] mem_wdata_a [N];
    logic [7:0] mem_rdata_a [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            mem_bus_arbiter_if #(.AW(8), .DW(8)) bus ();
            assign bus.i_req       = req_a[g];
            assign bus.i_we        = we_a[g];
            assign bus.i_addr0     = addr0_a[g];
            assign bus.i_addr1     = addr1_a[g];
            assign bus.i_wdata0    = wdata0_a[g];
            assign bus.i_wdata1    = wdata1_a[g];
            assign bus.i_mem_rdata = mem_rdata_a[g];
            assign gnt_a[g]        = bus.o_gnt;
            assign rvalid_a[g]     = bus.o_rvalid;
            assign rdata_a[g]      = bus.o_rdata;
            assign busy_a[g]       = bus.o_busy;
            assign mem_en_a[g]     = bus.o_mem_en;
            assign mem_we_a[g]     = bus.o_mem_we;
            assign mem_addr_a[g]   = bus.o_mem_addr;
            assign mem_wdata_a[g]  = bus.o_mem_wdata;

            mem_bus_arbiter #(
                .AW(8), .DW(8),
                .MEM_LAT((g == 2) ? 4 : 1),
                .FIXED_PRIO((g == 1) ? 1 : 0)
            ) u_dut (
                .clk(clk),
                .rst(rst),
                .bus(bus)
            );
        end
    endgenerate

    // Memory model: read data is correct only exactly MEM_LAT cycles after mem_en.
    logic [7:0] mem [256];
    logic [7:0] pend_addr [N];
    logic [4:0] pend_cnt [N];

    function automatic logic [7:0] mem_init(input logic [7:0] a);
        if (a == 8'h10) return 8'hA5;
        return a ^ 8'h5A;
    endfunction

    function automatic logic [4:0] lat_of(input int k);
        return (k == 2) ? 5'd4 : 5'd1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= mem_init(8'(i));
            for (int k = 0; k < N; k++) begin
                pend_cnt[k]  <= 5'd0;
                pend_addr[k] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (mem_en_a[k] && mem_we_a[k]) mem[mem_addr_a[k]] <= mem_wdata_a[k];
                if (mem_en_a[k] && !mem_we_a[k]) begin
                    pend_addr[k] <= mem_addr_a[k];
                    pend_cnt[k]  <= 5'd1;
                end else if (pend_cnt[k] != 5'd0 && pend_cnt[k] != 5'd31) begin
                    pend_cnt[k] <= pend_cnt[k] + 5'd1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            mem_rdata_a[k] = (pend_cnt[k] == lat_of(k)) ? mem[pend_addr[k]] : ~mem[pend_addr[k]];
        end
    end

    int   sel = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   t_req = 0;
    int   t_gnt = 0;
    int   t_rv = 0;
    int   rv_seen = 0;
    txn_t tx0 [$];
    txn_t tx1 [$];
    acc_t exp_acc [$];
    rd_t  exp_rd [$];
    logic [1:0] gnt_hist [$];

    task automatic load_port(input int p);
        txn_t t;
        logic have;
        have = 1'b0;
        t    = '0;
        if (p == 0 && tx0.size() > 0) begin
            t = tx0.pop_front();
            have = 1'b1;
        end else if (p == 1 && tx1.size() > 0) begin
            t = tx1.pop_front();
            have = 1'b1;
        end
        if (have && !req_a[sel][p]) t_req = cyc;
        req_a[sel][p] = have;
        we_a[sel][p]  = have ? t.we : 1'b0;
        if (p == 0) begin
            addr0_a[sel]  = t.addr;
            wdata0_a[sel] = t.wdata;
        end else begin
            addr1_a[sel]  = t.addr;
            wdata1_a[sel] = t.wdata;
        end
    endtask

    // Requester + scoreboard monitor for the selected instance, one step per negedge.
    task automatic bfm();
        acc_t e;
        rd_t  r;
        forever begin
            @(negedge clk);
            if (gnt_a[sel] != 2'b00) begin
                t_gnt = cyc;
                gnt_hist.push_back(gnt_a[sel]);
                n_checks++;
                if (exp_acc.size() == 0) begin
                    $display("FAIL sb_gnt: unexpected gnt=%b at cycle %0d", gnt_a[sel], cyc);
                end else begin
                    e = exp_acc.pop_front();
                    if ({gnt_a[sel], mem_en_a[sel], mem_we_a[sel], mem_addr_a[sel], mem_wdata_a[sel], rvalid_a[sel]}
                        !== {e.gnt, 1'b1, e.we, e.addr, e.wdata, 2'b00}) begin
                        $display("FAIL sb_issue: got gnt=%b en=%b we=%b addr=%h wd=%h rv=%b, want gnt=%b en=1 we=%b addr=%h wd=%h rv=00",
                                 gnt_a[sel], mem_en_a[sel], mem_we_a[sel], mem_addr_a[sel], mem_wdata_a[sel],
                                 rvalid_a[sel], e.gnt, e.we, e.addr, e.wdata);
                    end else begin
                        n_pass++;
                    end
                    if (!e.we) exp_rd.push_back('{rv: e.gnt, data: e.rdata});
                end
            end
            if (rvalid_a[sel] != 2'b00) begin
                t_rv = cyc;
                rv_seen++;
                n_checks++;
                if (exp_rd.size() == 0) begin
                    $display("FAIL sb_rvalid: unexpected rvalid=%b rdata=%h at cycle %0d", rvalid_a[sel], rdata_a[sel], cyc);
                end else begin
                    r = exp_rd.pop_front();
                    if ({rvalid_a[sel], rdata_a[sel], gnt_a[sel]} !== {r.rv, r.data, 2'b00}) begin
                        $display("FAIL sb_rdata: got rvalid=%b rdata=%h gnt=%b, want rvalid=%b rdata=%h gnt=00",
                                 rvalid_a[sel], rdata_a[sel], gnt_a[sel], r.rv, r.data);
                    end else begin
                        n_pass++;
                    end
                end
            end
            if (!rst) begin
                for (int p = 0; p < 2; p++) begin
                    if ((req_a[sel][p] && gnt_a[sel][p]) || !req_a[sel][p]) load_port(p);
                end
            end
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            req_a[k] = 2'b00;   we_a[k] = 2'b00;
            addr0_a[k] = 8'h00; addr1_a[k] = 8'h00;
            wdata0_a[k] = 8'h00; wdata1_a[k] = 8'h00;
        end
        tx0.delete(); tx1.delete(); exp_acc.delete(); exp_rd.delete(); gnt_hist.delete();
    endtask

    task automatic do_reset(input int which);
        rst = 1'b1;
        clear_all();
        sel = which;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_txn(input int p, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        if (p == 0) tx0.push_back('{we: we, addr: addr, wdata: wdata});
        else        tx1.push_back('{we: we, addr: addr, wdata: wdata});
    endtask

    task automatic push_exp(input int p, input logic we, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [7:0] rdata);
        exp_acc.push_back('{gnt: (p == 1) ? 2'b10 : 2'b01, we: we, addr: addr, wdata: wdata, rdata: rdata});
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (tx0.size() == 0 && tx1.size() == 0 && exp_acc.size() == 0 && exp_rd.size() == 0 &&
                req_a[sel] == 2'b00 && !busy_a[sel]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_gnt(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (gnt_a[sel] != 2'b00) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit seen;
        int rv_before;
        rst = 1'b1;
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            n_checks++;
            if ({gnt_a[k], rvalid_a[k], rdata_a[k], busy_a[k], mem_en_a[k], mem_we_a[k], mem_addr_a[k], mem_wdata_a[k]} !== 32'h0)
                $display("FAIL reset_outputs[%0d]: gnt=%b rv=%b rdata=%h busy=%b en=%b, want all 0",
                         k, gnt_a[k], rvalid_a[k], rdata_a[k], busy_a[k], mem_en_a[k]);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
        sel = 0;
        push_txn(0, 1'b0, 8'h33, 8'h00);
        push_exp(0, 1'b0, 8'h33, 8'h00, mem_init(8'h33));
        wait_gnt(20, seen);
        n_checks++;
        if (seen !== 1'b1) $display("FAIL reset_pre_gnt: gnt seen=%b, want 1", seen);
        else n_pass++;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({gnt_a[0], rvalid_a[0], busy_a[0], mem_en_a[0], mem_addr_a[0]} !== 14'h0)
            $display("FAIL reset_mid_read: gnt=%b rv=%b busy=%b en=%b addr=%h, want all 0",
                     gnt_a[0], rvalid_a[0], busy_a[0], mem_en_a[0], mem_addr_a[0]);
        else n_pass++;
        exp_rd.delete();
        rv_before = rv_seen;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if ({rv_seen - rv_before, 31'(gnt_hist.size()), busy_a[0]} !== {32'd0, 31'd1, 1'b0})
            $display("FAIL reset_dropped: rvalids=%0d grants=%0d busy=%b, want 0 1 0",
                     rv_seen - rv_before, gnt_hist.size(), busy_a[0]);
        else n_pass++;
    endtask

    task automatic test_read();
        bit ok;
        do_reset(0);
        push_txn(0, 1'b0, 8'h10, 8'h00);
        push_exp(0, 1'b0, 8'h10, 8'h00, 8'hA5);
        wait_drain(50, ok);
        n_checks++;
        if ({ok, t_gnt - t_req, t_rv - t_req} !== {1'b1, 32'd1, 32'd3})
            $display("FAIL read_latency: done=%b gnt@T+%0d rvalid@T+%0d, want 1 T+1 T+3", ok, t_gnt - t_req, t_rv - t_req);
        else n_pass++;
        n_checks++;
        if (rdata_a[0] !== 8'hA5) $display("FAIL read_rdata_hold: rdata=%h, want a5", rdata_a[0]);
        else n_pass++;
    endtask

    task automatic test_write();
        bit seen;
        bit ok;
        do_reset(0);
        push_txn(1, 1'b1, 8'h20, 8'h3C);
        push_exp(1, 1'b1, 8'h20, 8'h3C, 8'h00);
        wait_gnt(20, seen);
        n_checks++;
        if ({seen, t_gnt - t_req} !== {1'b1, 32'd1})
            $display("FAIL write_gnt: seen=%b gnt@T+%0d, want 1 T+1", seen, t_gnt - t_req);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if ({busy_a[0], rvalid_a[0], mem_en_a[0], mem_we_a[0]} !== 5'b0)
            $display("FAIL write_done: busy=%b rvalid=%b en=%b we=%b at T+2, want all 0",
                     busy_a[0], rvalid_a[0], mem_en_a[0], mem_we_a[0]);
        else n_pass++;
        push_txn(0, 1'b0, 8'h20, 8'h00);
        push_exp(0, 1'b0, 8'h20, 8'h00, 8'h3C);
        wait_drain(50, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL write_readback_drain: done=%b, want 1", ok);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [1:0] want [6];
        do_reset(0);
        for (int i = 0; i < 3; i++) begin
            push_txn(0, 1'b0, 8'h40 + 8'(i), 8'h00);
            push_txn(1, 1'b0, 8'h50 + 8'(i), 8'h00);
            push_exp(0, 1'b0, 8'h40 + 8'(i), 8'h00, mem_init(8'h40 + 8'(i)));
            push_exp(1, 1'b0, 8'h50 + 8'(i), 8'h00, mem_init(8'h50 + 8'(i)));
            want[2*i]   = 2'b01;
            want[2*i+1] = 2'b10;
        end
        wait_drain(200, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL rr_drain: done=%b, want 1", ok);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= gnt_hist.size()) $display("FAIL rr_order[%0d]: no grant, want %b", i, want[i]);
            else if (gnt_hist[i] !== want[i]) $display("FAIL rr_order[%0d]: gnt=%b, want %b", i, gnt_hist[i], want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_fixed_prio();
        bit ok;
        logic [1:0] want [5];
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            push_txn(1, 1'b0, 8'h70 + 8'(i), 8'h00);
            push_exp(1, 1'b0, 8'h70 + 8'(i), 8'h00, mem_init(8'h70 + 8'(i)));
            want[i] = 2'b10;
        end
        for (int i = 0; i < 2; i++) begin
            push_txn(0, 1'b0, 8'h60 + 8'(i), 8'h00);
            push_exp(0, 1'b0, 8'h60 + 8'(i), 8'h00, mem_init(8'h60 + 8'(i)));
            want[3+i] = 2'b01;
        end
        wait_drain(200, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL fp_drain: done=%b, want 1", ok);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= gnt_hist.size()) $display("FAIL fp_order[%0d]: no grant, want %b", i, want[i]);
            else if (gnt_hist[i] !== want[i]) $display("FAIL fp_order[%0d]: gnt=%b, want %b", i, gnt_hist[i], want[i]);
            else n_pass++;
        end
    endtask

    task automatic test_long_latency();
        bit ok;
        do_reset(2);
        push_txn(0, 1'b0, 8'h88, 8'h00);
        push_exp(0, 1'b0, 8'h88, 8'h00, 8'hD2);
        wait_drain(50, ok);
        n_checks++;
        if ({ok, t_gnt - t_req, t_rv - t_req} !== {1'b1, 32'd1, 32'd6})
            $display("FAIL lat4_latency: done=%b gnt@T+%0d rvalid@T+%0d, want 1 T+1 T+6", ok, t_gnt - t_req, t_rv - t_req);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset(0);
        push_txn(0, 1'b1, 8'h90, 8'h11);
        push_txn(0, 1'b0, 8'h91, 8'h00);
        push_txn(1, 1'b0, 8'h90, 8'h00);
        push_txn(1, 1'b1, 8'h91, 8'h22);
        push_exp(0, 1'b1, 8'h90, 8'h11, 8'h00);
        push_exp(1, 1'b0, 8'h90, 8'h00, 8'h11);
        push_exp(0, 1'b0, 8'h91, 8'h00, 8'hCB);
        push_exp(1, 1'b1, 8'h91, 8'h22, 8'h00);
        wait_drain(200, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL b2b_drain: done=%b, want 1", ok);
        else n_pass++;
        n_checks++;
        if (gnt_hist.size() !== 4) $display("FAIL b2b_grants: count=%0d, want 4", gnt_hist.size());
        else n_pass++;
    endtask

    initial begin
        fork
            bfm();
        join_none
        test_reset();
        test_read();
        test_write();
        test_round_robin();
        test_fixed_prio();
        test_long_latency();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
